// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes, RV32I opcodes and decode helpers.
// Imported by the decode stage and by the ALU itself.
package alu_pkg;

  localparam logic [3:0] ALU_ADD     = 4'b0000;
  localparam logic [3:0] ALU_SUB     = 4'b0001;
  localparam logic [3:0] ALU_SLL     = 4'b0010;
  localparam logic [3:0] ALU_SLT     = 4'b0011;
  localparam logic [3:0] ALU_SLTU    = 4'b0100;
  localparam logic [3:0] ALU_XOR     = 4'b0101;
  localparam logic [3:0] ALU_SRL     = 4'b0110;
  localparam logic [3:0] ALU_SRA     = 4'b0111;
  localparam logic [3:0] ALU_OR      = 4'b1000;
  localparam logic [3:0] ALU_AND     = 4'b1001;
  localparam logic [3:0] ALU_INVALID = 4'b1111;

  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [6:0] FUNCT7_ALT = 7'b0100000;

  // Occupancy of the 2-entry output buffer; SB_FULL means the skid entry holds data.
  typedef enum logic [1:0] {
    SB_EMPTY = 2'd0,
    SB_MAIN  = 2'd1,
    SB_FULL  = 2'd2
  } skid_state_t;

  // Base operation for the funct3 field of register/immediate arithmetic.
  function automatic logic [3:0] funct3_base_op(input logic [2:0] funct3);
    logic [3:0] op;
    case (funct3)
      3'b000:  op = ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_op_decoder_if.sv
// Decode-stage bus: instruction fields in, ALU operands/control out.
// Both sides use valid/ready: a transfer happens on a rising edge where valid
// and ready are both high; once valid is raised, it and its data hold until that edge.
interface alu_op_decoder_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [6:0]      in_opcode;
  logic [2:0]      in_funct3;
  logic [6:0]      in_funct7;
  logic [XLEN-1:0] in_rs1_data;
  logic [XLEN-1:0] in_rs2_data;
  logic [XLEN-1:0] in_imm;
  logic [XLEN-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_operand_a;
  logic [XLEN-1:0] out_operand_b;
  logic [3:0]      out_alu_control;
  logic            out_illegal;

  modport master (
    output in_valid, in_opcode, in_funct3, in_funct7,
           in_rs1_data, in_rs2_data, in_imm, in_pc, out_ready,
    input  in_ready, out_valid, out_operand_a, out_operand_b,
           out_alu_control, out_illegal
  );

  modport slave (
    input  in_valid, in_opcode, in_funct3, in_funct7,
           in_rs1_data, in_rs2_data, in_imm, in_pc, out_ready,
    output in_ready, out_valid, out_operand_a, out_operand_b,
           out_alu_control, out_illegal
  );
endinterface

// File: rtl/alu_op_decoder_skid_buffer.sv
// Two-entry valid/ready buffer: a main output register plus one skid entry.
// in_ready depends only on the state register, so no combinational ready path.
module skid_buffer
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output skid_state_t      state
);

  skid_state_t      state_q;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SB_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      case (state_q)
        SB_EMPTY: begin
          if (in_valid) begin
            main_q  <= in_data;
            state_q <= SB_MAIN;
          end
        end
        SB_MAIN: begin
          case ({in_valid, out_ready})
            2'b10: begin
              skid_q  <= in_data;
              state_q <= SB_FULL;
            end
            2'b11:   main_q  <= in_data;
            2'b01:   state_q <= SB_EMPTY;
            default: state_q <= SB_MAIN;
          endcase
        end
        SB_FULL: begin
          // Input is blocked here, so draining the skid is the only move.
          if (out_ready) begin
            main_q  <= skid_q;
            state_q <= SB_MAIN;
          end
        end
        default: state_q <= SB_EMPTY;
      endcase
    end
  end

  assign in_ready  = (state_q != SB_FULL);
  assign out_valid = (state_q != SB_EMPTY);
  assign out_data  = main_q;
  assign state     = state_q;

endmodule

// File: rtl/alu_op_decoder.sv
// RV32I decode stage: maps instruction fields to ALU operands and control,
// registered behind a skid buffer. Unsupported encodings flow through as illegal.
module alu_op_decoder
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic          clk,
  input  logic          rst,
  alu_op_decoder_if.slave bus,
  output skid_state_t   dbg_state
);

  localparam int PW = 2 * XLEN + 5;

  logic            dec_illegal;
  logic [3:0]      dec_ctrl;
  logic [XLEN-1:0] dec_a;
  logic [XLEN-1:0] dec_b;
  logic [PW-1:0]   dec_payload;
  logic [PW-1:0]   out_payload;

  always_comb begin
    dec_illegal = 1'b0;
    dec_ctrl    = ALU_ADD;
    dec_a       = bus.in_rs1_data;
    dec_b       = bus.in_imm;
    case (bus.in_opcode)
      OP_REG: begin
        dec_b = bus.in_rs2_data;
        if (bus.in_funct7 == 7'b0000000)
          dec_ctrl = funct3_base_op(bus.in_funct3);
        else if (bus.in_funct7 == FUNCT7_ALT && bus.in_funct3 == 3'b000)
          dec_ctrl = ALU_SUB;
        else if (bus.in_funct7 == FUNCT7_ALT && bus.in_funct3 == 3'b101)
          dec_ctrl = ALU_SRA;
        else
          dec_illegal = 1'b1;
      end
      OP_IMM: begin
        // funct7 is only meaningful for the shift-immediate forms.
        case (bus.in_funct3)
          3'b001: begin
            if (bus.in_funct7 == 7'b0000000) dec_ctrl = ALU_SLL;
            else                             dec_illegal = 1'b1;
          end
          3'b101: begin
            if (bus.in_funct7 == 7'b0000000)   dec_ctrl = ALU_SRL;
            else if (bus.in_funct7 == FUNCT7_ALT) dec_ctrl = ALU_SRA;
            else                               dec_illegal = 1'b1;
          end
          default: dec_ctrl = funct3_base_op(bus.in_funct3);
        endcase
      end
      OP_LUI:   dec_a = '0;
      OP_AUIPC: dec_a = bus.in_pc;
      OP_LOAD, OP_STORE: begin
        dec_ctrl = ALU_ADD;
      end
      OP_BRANCH: begin
        dec_b = bus.in_rs2_data;
        case (bus.in_funct3[2:1])
          2'b00:   dec_ctrl = ALU_SUB;
          2'b10:   dec_ctrl = ALU_SLT;
          2'b11:   dec_ctrl = ALU_SLTU;
          default: dec_illegal = 1'b1;
        endcase
      end
      OP_JAL, OP_JALR: begin
        dec_a = bus.in_pc;
        dec_b = XLEN'(4);
      end
      default: dec_illegal = 1'b1;
    endcase

    if (dec_illegal) begin
      dec_ctrl = ALU_INVALID;
      dec_a    = '0;
      dec_b    = '0;
    end
  end

  assign dec_payload = {dec_illegal, dec_ctrl, dec_a, dec_b};

  skid_buffer #(
    .WIDTH(PW)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .in_valid (bus.in_valid),
    .in_ready (bus.in_ready),
    .in_data  (dec_payload),
    .out_valid(bus.out_valid),
    .out_ready(bus.out_ready),
    .out_data (out_payload),
    .state    (dbg_state)
  );

  assign {bus.out_illegal, bus.out_alu_control, bus.out_operand_a, bus.out_operand_b} = out_payload;

endmodule

// File: tb/tb_alu_op_decoder.sv
// Bench for alu_op_decoder: directed decode/handshake steps and a random stream,
// scored against a table-driven RV32I decode model and an in-order expected queue.
module tb_alu_op_decoder;
  import alu_pkg::*;

  localparam int XLEN = 32;
  localparam int PW   = 2 * XLEN + 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_op_decoder_if #(.XLEN(XLEN)) bus ();
  skid_state_t dbg_state;

  alu_op_decoder #(.XLEN(XLEN)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .dbg_state(dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [PW-1:0] exp_q[$];

  // Reference decode written straight from the instruction tables.
  function automatic logic [PW-1:0] ref_decode(
    input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
    input logic [31:0] rs1, input logic [31:0] rs2,
    input logic [31:0] imm, input logic [31:0] pc);
    int f3_code [8];
    logic [3:0]  code;
    logic [31:0] a, b;
    bit ok;
    f3_code = '{0, 2, 3, 4, 5, 6, 8, 9};
    ok = 1; code = 0; a = 0; b = 0;
    if (op == 7'b0110011) begin
      a = rs1; b = rs2;
      if (f7 == 0)                      code = 4'(f3_code[f3]);
      else if (f7 == 7'h20 && f3 == 0)  code = 1;
      else if (f7 == 7'h20 && f3 == 5)  code = 7;
      else                              ok = 0;
    end else if (op == 7'b0010011) begin
      a = rs1; b = imm; code = 4'(f3_code[f3]);
      if (f3 == 1 && f7 != 0) ok = 0;
      if (f3 == 5) begin
        if (f7 == 7'h20)   code = 7;
        else if (f7 != 0)  ok = 0;
      end
    end else if (op == 7'b0110111) begin
      a = 0; b = imm; code = 0;
    end else if (op == 7'b0010111) begin
      a = pc; b = imm; code = 0;
    end else if (op == 7'b0000011 || op == 7'b0100011) begin
      a = rs1; b = imm; code = 0;
    end else if (op == 7'b1100011) begin
      a = rs1; b = rs2;
      if (f3 < 2)       code = 1;
      else if (f3 < 4)  ok = 0;
      else if (f3 < 6)  code = 3;
      else              code = 4;
    end else if (op == 7'b1101111 || op == 7'b1100111) begin
      a = pc; b = 4; code = 0;
    end else begin
      ok = 0;
    end
    if (!ok) return {1'b1, 4'hF, 64'h0};
    return {1'b0, code, a, b};
  endfunction

  task automatic check(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [PW-1:0] out_payload();
    return {bus.out_illegal, bus.out_alu_control, bus.out_operand_a, bus.out_operand_b};
  endfunction

  task automatic drive(input logic v, input logic [6:0] op, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [31:0] rs1, input logic [31:0] rs2,
                       input logic [31:0] imm, input logic [31:0] pc);
    bus.in_valid    = v;
    bus.in_opcode   = op;
    bus.in_funct3   = f3;
    bus.in_funct7   = f7;
    bus.in_rs1_data = rs1;
    bus.in_rs2_data = rs2;
    bus.in_imm      = imm;
    bus.in_pc       = pc;
  endtask

  // One clock: score the current outputs, account for the transfers of the
  // coming edge, then advance to just after that edge.
  task automatic tick();
    logic acc, cons;
    check("out_valid", bus.out_valid, exp_q.size() != 0);
    check("in_ready", bus.in_ready, exp_q.size() < 2);
    if (bus.out_valid && exp_q.size() > 0) check("payload", out_payload(), exp_q[0]);
    acc  = bus.in_valid && bus.in_ready;
    cons = bus.out_valid && bus.out_ready;
    if (cons && exp_q.size() > 0) void'(exp_q.pop_front());
    if (acc) exp_q.push_back(ref_decode(bus.in_opcode, bus.in_funct3, bus.in_funct7,
                                        bus.in_rs1_data, bus.in_rs2_data, bus.in_imm, bus.in_pc));
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [31:0] rs1, input logic [31:0] rs2,
                      input logic [31:0] imm, input logic [31:0] pc);
    logic got;
    got = 1'b0;
    drive(1'b1, op, f3, f7, rs1, rs2, imm, pc);
    for (int i = 0; i < 20 && !got; i++) begin
      got = bus.in_ready;
      tick();
    end
    bus.in_valid = 1'b0;
    check("send_accept", got, 1'b1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_out_valid"}, bus.out_valid, 1'b0);
    check({tag, "_in_ready"}, bus.in_ready, 1'b1);
    check({tag, "_data"}, out_payload(), '0);
    check({tag, "_state"}, dbg_state, SB_EMPTY);
  endtask

  initial begin
    logic [6:0] ops [10];
    int acc_n;
    ops = '{7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111, 7'b0000011,
            7'b0100011, 7'b1100011, 7'b1101111, 7'b1100111, 7'b0};

    // Clock / reset
    rst = 1'b1;
    bus.out_ready = 1'b0;
    drive(1'b0, 7'b0, 3'b0, 7'b0, 0, 0, 0, 0);
    #1;
    check_idle_outputs("reset_init");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // R-type decode
    bus.out_ready = 1'b1;
    send(7'b0110011, 3'b000, 7'b0100000, 10, 3, 32'h55, 0);
    check("sub_a", bus.out_operand_a, 10);
    check("sub_b", bus.out_operand_b, 3);
    check("sub_ctrl", bus.out_alu_control, 4'b0001);
    send(7'b0110011, 3'b101, 7'b0100000, 32'h8000_0000, 5, 0, 0);
    check("sra_ctrl", bus.out_alu_control, 4'b0111);

    // I-type and upper immediate
    send(7'b0010011, 3'b101, 7'b0000001, 32'h1234, 0, 32'h3, 0);
    check("srai_bad_illegal", bus.out_illegal, 1'b1);
    check("srai_bad_ctrl", bus.out_alu_control, 4'b1111);
    check("srai_bad_ops", {bus.out_operand_a, bus.out_operand_b}, 64'h0);
    send(7'b0010111, 3'b000, 7'b0, 32'h77, 0, 32'h3000, 32'h100);
    check("auipc_a", bus.out_operand_a, 32'h100);
    check("auipc_b", bus.out_operand_b, 32'h3000);
    check("auipc_ctrl", bus.out_alu_control, 4'b0000);

    // Branch and jump
    send(7'b1100011, 3'b110, 7'b0, 7, 9, 32'h10, 0);
    check("bltu_ctrl", bus.out_alu_control, 4'b0100);
    send(7'b1101111, 3'b000, 7'b0, 1, 2, 32'h800, 32'h40);
    check("jal_a", bus.out_operand_a, 32'h40);
    check("jal_b", bus.out_operand_b, 4);
    check("jal_ctrl", bus.out_alu_control, 4'b0000);
    send(7'b1110011, 3'b000, 7'b0, 1, 2, 3, 4);
    check("system_illegal", bus.out_illegal, 1'b1);
    drive(1'b0, 7'b0, 3'b0, 7'b0, 0, 0, 0, 0);
    repeat (2) tick();

    // Backpressure and skid
    bus.out_ready = 1'b0;
    send(7'b0110011, 3'b000, 7'b0, 1, 0, 0, 0);
    send(7'b0110011, 3'b000, 7'b0, 2, 0, 0, 0);
    check("skid_full_ready", bus.in_ready, 1'b0);
    check("skid_full_state", dbg_state, SB_FULL);
    drive(1'b1, 7'b0110011, 3'b000, 7'b0, 3, 0, 0, 0);
    repeat (2) tick();
    bus.out_ready = 1'b1;
    check("release_first_a", bus.out_operand_a, 1);
    tick();
    check("drain_second_a", bus.out_operand_a, 2);
    check("drain_ready", bus.in_ready, 1'b1);
    tick();
    bus.in_valid = 1'b0;
    check("third_a", bus.out_operand_a, 3);
    repeat (2) tick();

    // Reset mid-stream with both entries full
    bus.out_ready = 1'b0;
    send(7'b0110111, 3'b000, 7'b0, 0, 0, 32'hABC000, 0);
    send(7'b0110011, 3'b111, 7'b0, 5, 6, 0, 0);
    #2 rst = 1'b1;
    #1;
    check_idle_outputs("reset_mid");
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Random stream with random backpressure
    acc_n = 0;
    for (int cyc = 0; cyc < 20000 && acc_n < 1000; cyc++) begin
      logic [6:0] f7;
      int k;
      k = $urandom_range(0, 2);
      f7 = (k == 0) ? 7'h00 : (k == 1) ? 7'h20 : 7'($urandom);
      k = $urandom_range(0, 9);
      drive($urandom_range(0, 3) != 0, (k == 9) ? 7'($urandom) : ops[k], 3'($urandom), f7,
            $urandom, $urandom, $urandom, $urandom);
      bus.out_ready = $urandom_range(0, 3) != 0;
      if (bus.in_valid && bus.in_ready) acc_n++;
      tick();
    end
    check("random_count", acc_n, 1000);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (4) tick();
    check("drain_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
